// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle RV32I control path:
// FSM states, opcode encodings and ALU operation codes.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC_INC = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd7;
  localparam logic [3:0] ALU_BNE = 4'd8;
  localparam logic [3:0] ALU_BLT = 4'd9;
  localparam logic [3:0] ALU_BGE = 4'd10;

  // Opcodes that go through EX; anything else retires as a NOP.
  function automatic logic op_executes(input logic [6:0] op);
    return (op == OP_R)      || (op == OP_I)     ||
           (op == OP_LOAD)   || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL)   ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_control_unit.sv
// Combinational funct3/funct7 to alu_op decoder.
// Without use_funct the ALU is told to ADD.
module alu_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       use_funct,
  output logic [3:0] alu_op
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Branch compares vs. arithmetic, SUB only for R-type
  always_comb begin
    alu_op = ALU_ADD;
    if (use_funct) begin
      if (opcode == OP_BRANCH) begin
        unique case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          default: alu_op = ALU_BEQ;
        endcase
      end else begin
        unique case (funct3)
          3'b000: begin
            if (opcode == OP_R && funct7[5])
              alu_op = ALU_SUB;
            else
              alu_op = ALU_ADD;
          end
          3'b001:  alu_op = ALU_SLL;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: IF/ID/EX/MEM/WB/PC_INC
// sequencing with datapath selects derived from state.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_bcond,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       is_ecall
);

  state_e state_q, state_d;
  logic   use_funct;

  logic is_r, is_i, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_ec;

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_ld   = (opcode == OP_LOAD);
  assign is_st   = (opcode == OP_STORE);
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_ec   = (opcode == OP_ECALL);

  // State register; reset restarts at fetch
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IF;
    else
      state_q <= state_d;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_ec || !op_executes(opcode))
          state_d = S_PC_INC;
        else
          state_d = S_EX;
      end
      S_EX: begin
        unique case (1'b1)
          is_r, is_i:      state_d = S_WB;
          is_ld, is_st:    state_d = S_MEM;
          is_br:
            state_d = alu_bcond ? S_IF : S_PC_INC;
          is_jal, is_jalr: state_d = S_IF;
          default:         state_d = S_PC_INC;
        endcase
      end
      S_MEM: state_d = is_ld ? S_WB : S_PC_INC;
      S_WB:     state_d = S_PC_INC;
      S_PC_INC: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Datapath controls; all forced low during reset
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    is_ecall      = 1'b0;
    use_funct     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = 1'b1;
        end
        S_ID: begin
          alu_src_b = 2'd2;
          is_ecall  = is_ec;
        end
        S_EX: begin
          unique case (1'b1)
            is_r: begin
              alu_src_a = 1'b1;
              use_funct = 1'b1;
            end
            is_i: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd2;
              use_funct = 1'b1;
            end
            is_ld, is_st: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd2;
            end
            is_br: begin
              alu_src_a     = 1'b1;
              use_funct     = 1'b1;
              pc_source     = 1'b1;
              pc_write_cond = alu_bcond;
            end
            is_jal, is_jalr: begin
              alu_src_a = is_jalr;
              alu_src_b = 2'd2;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              wb_sel    = 2'd2;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = is_ld;
          mem_write = is_st;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = is_ld ? 2'd1 : 2'd0;
        end
        S_PC_INC: begin
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_control_unit u_alu_ctl (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .use_funct (use_funct),
    .alu_op    (alu_op)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: reset, table of
// instruction vectors, corner sequences, random vs. model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_bcond;
  logic       pc_write, pc_write_cond, pc_source, iord;
  logic       mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b;
  logic       alu_src_a, is_ecall;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_bcond     (alu_bcond),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .is_ecall      (is_ecall)
  );

  typedef struct packed {
    logic       pcw, pcwc, pcs, iord;
    logic       mr, mw, irw, rw;
    logic [1:0] wbs;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic       ec;
  } out_t;

  out_t act;
  always_comb begin
    act = '{pc_write, pc_write_cond, pc_source, iord,
            mem_read, mem_write, ir_write, reg_write,
            wb_sel, alu_src_a, alu_src_b, alu_op,
            is_ecall};
  end

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] EC = 7'b1110011;

  // funct3-indexed ALU codes
  localparam logic [3:0] AR_TAB [8] =
    '{4'd0, 4'd4, 4'd0, 4'd0, 4'd6, 4'd5, 4'd2, 4'd3};
  localparam logic [3:0] BR_TAB [8] =
    '{4'd7, 4'd8, 4'd7, 4'd7, 4'd9, 4'd10, 4'd7, 4'd7};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Instruction length in cycles, IF inclusive
  function automatic int ref_len(logic [6:0] op,
                                 logic bc);
    case (op)
      R, I, ST: return 5;
      LD:       return 6;
      BR:       return bc ? 3 : 4;
      default:  return 3;
    endcase
  endfunction

  function automatic out_t ref_out(logic [6:0] op,
                                   logic [2:0] f3,
                                   logic [6:0] f7,
                                   logic bc, int c);
    out_t o;
    int   n;
    logic jmp;
    o   = '0;
    n   = ref_len(op, bc);
    jmp = (op == JL) || (op == JR) || (op == BR && bc);
    if (c == 0) begin
      o.mr = 1; o.irw = 1;
    end else if (c == 1) begin
      o.asb = 2; o.ec = (op == EC);
    end else if (c == n - 1 && !jmp) begin
      o.asb = 1; o.pcw = 1;
    end else if (c == 2) begin
      case (op)
        R: begin
          o.asa = 1;
          o.aop = (f3 == 0 && f7[5]) ? 4'd1 : AR_TAB[f3];
        end
        I: begin
          o.asa = 1; o.asb = 2; o.aop = AR_TAB[f3];
        end
        LD, ST: begin
          o.asa = 1; o.asb = 2;
        end
        BR: begin
          o.asa = 1; o.aop = BR_TAB[f3];
          o.pcs = 1; o.pcwc = bc;
        end
        default: begin
          o.asa = (op == JR); o.asb = 2;
          o.pcw = 1; o.rw = 1; o.wbs = 2;
        end
      endcase
    end else if (c == 3) begin
      if (op == LD) begin
        o.iord = 1; o.mr = 1;
      end else if (op == ST) begin
        o.iord = 1; o.mw = 1;
      end else begin
        o.rw = 1;
      end
    end else if (c == 4) begin
      o.rw = 1; o.wbs = 1;
    end
    return o;
  endfunction

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bc;
    int         len;
    logic [3:0] exop;
    int         ec, rw, mw;
  } vec_t;

  vec_t tv[$];

  task automatic add(string nm, logic [6:0] op,
                     logic [2:0] f3, logic [6:0] f7,
                     logic bc, int len, logic [3:0] exop,
                     int ec, int rw, int mw);
    vec_t v;
    v = '{nm, op, f3, f7, bc, len, exop, ec, rw, mw};
    tv.push_back(v);
  endtask

  task automatic resync();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    #1;
  endtask

  // Entry and exit: positioned inside an IF cycle
  task automatic run_vec(vec_t v);
    int   k;
    logic seen;
    logic [3:0] exop;
    int   ec, rw, mw;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    alu_bcond = v.bc;
    seen = 0; exop = 0; ec = 0; rw = 0; mw = 0; k = 0;
    for (int j = 1; j <= 10 && !seen; j++) begin
      @(negedge clk); #1;
      if (act.mr && act.irw && !act.iord) begin
        seen = 1; k = j;
      end else begin
        if (j == 2) exop = act.aop;
        ec += int'(act.ec);
        rw += int'(act.rw);
        mw += int'(act.mw);
      end
    end
    if (!seen) begin
      chk({v.nm, " timeout"}, 0, 1);
      resync();
    end else begin
      chk({v.nm, " len"}, k, v.len);
      chk({v.nm, " exop"}, exop, v.exop);
      chk({v.nm, " ecall"}, ec, v.ec);
      chk({v.nm, " rwcnt"}, rw, v.rw);
      chk({v.nm, " mwcnt"}, mw, v.mw);
    end
  endtask

  task automatic run_model(logic [6:0] op, logic [2:0] f3,
                           logic [6:0] f7, logic bc,
                           int idx);
    int   n;
    out_t e;
    n = ref_len(op, bc);
    opcode = op; funct3 = f3; funct7 = f7;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(negedge clk);
        alu_bcond = (c == 2) ? bc : 1'($urandom);
        #1;
      end
      e = ref_out(op, f3, f7, bc, c);
      chk($sformatf("rnd%0d op%0h c%0d", idx, op, c),
          32'(act), 32'(e));
    end
    @(negedge clk); #1;
  endtask

  initial begin
    out_t e;
    logic [6:0] ops [8];
    logic [6:0] op;
    ops = '{R, I, LD, ST, BR, JL, JR, EC};

    reset = 1; opcode = ST; funct3 = 0; funct7 = 0;
    alu_bcond = 1;
    @(negedge clk); #1;
    chk("reset c1", 32'(act), 0);
    @(negedge clk); #1;
    chk("reset c2", 32'(act), 0);
    @(negedge clk); reset = 0; #1;
    e = ref_out(R, 0, 0, 0, 0);
    chk("if after reset", 32'(act), 32'(e));

    add("sub",   R,  3'b000, 7'h20, 0, 5, 4'd1, 0, 1, 0);
    add("add",   R,  3'b000, 7'h00, 0, 5, 4'd0, 0, 1, 0);
    add("and",   R,  3'b111, 7'h00, 1, 5, 4'd3, 0, 1, 0);
    add("xori",  I,  3'b100, 7'h00, 0, 5, 4'd6, 0, 1, 0);
    add("addi7", I,  3'b000, 7'h20, 0, 5, 4'd0, 0, 1, 0);
    add("srli",  I,  3'b101, 7'h00, 0, 5, 4'd5, 0, 1, 0);
    add("slti",  I,  3'b010, 7'h00, 0, 5, 4'd0, 0, 1, 0);
    add("load",  LD, 3'b010, 7'h7f, 0, 6, 4'd0, 0, 1, 0);
    add("store", ST, 3'b010, 7'h00, 1, 5, 4'd0, 0, 0, 1);
    add("bne_t", BR, 3'b001, 7'h00, 1, 3, 4'd8, 0, 0, 0);
    add("bne_n", BR, 3'b001, 7'h00, 0, 4, 4'd8, 0, 0, 0);
    add("blt_t", BR, 3'b100, 7'h00, 1, 3, 4'd9, 0, 0, 0);
    add("bge_n", BR, 3'b101, 7'h20, 0, 4, 4'd10, 0, 0, 0);
    add("b010",  BR, 3'b010, 7'h00, 1, 3, 4'd7, 0, 0, 0);
    add("jal",   JL, 3'b000, 7'h00, 0, 3, 4'd0, 0, 1, 0);
    add("jalr",  JR, 3'b000, 7'h00, 1, 3, 4'd0, 0, 1, 0);
    add("ecall", EC, 3'b000, 7'h00, 0, 3, 4'd0, 1, 0, 0);
    add("unk",   7'h00, 3'b000, 7'h20, 1, 3, 4'd0, 0, 0, 0);
    foreach (tv[i]) run_vec(tv[i]);

    // JALR EX detail
    opcode = JR; funct3 = 0; funct7 = 0; alu_bcond = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("jalr ex asa", 32'(act.asa), 1);
    chk("jalr ex asb", 32'(act.asb), 2);
    chk("jalr ex wbs", 32'(act.wbs), 2);
    chk("jalr ex pcw", 32'(act.pcw & act.rw), 1);
    @(negedge clk); #1;
    chk("jalr then if", 32'(act.mr & act.irw), 1);

    // Reset during MEM of a store
    opcode = ST; funct3 = 3'b010; funct7 = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); reset = 1; #1;
    chk("mid reset mw", 32'(act.mw), 0);
    chk("mid reset all", 32'(act), 0);
    @(negedge clk); reset = 0; #1;
    e = ref_out(ST, 0, 0, 0, 0);
    chk("mid reset if", 32'(act), 32'(e));

    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      op = (r < 8) ? ops[r] : 7'($urandom);
      run_model(op, 3'($urandom), 7'($urandom),
                1'($urandom), n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Finite-state controller for the multi-cycle RV32I core. It is the driving end of the ALU interface: it sequences every instruction through fetch, decode, execute, memory and write-back, and selects the ALU operands and `alu_op` for each step. It consumes `alu_bcond` back from the ALU. It sits beside the datapath and drives every mux select and write enable in it.

## Interface
- No parameters. Widths are fixed by the RV32I encoding.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7` in 7: IR[31:25].
- `alu_bcond` in 1: branch-condition result from the ALU.
- `pc_write` out 1: unconditional PC write enable.
- `pc_write_cond` out 1: PC write enable gated by `alu_bcond`. Already ANDed inside this block.
- `pc_source` out 1: selects the PC input. 0 = ALU result, 1 = ALUOut register.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `ir_write` out 1: instruction register load enable.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: register write-data select. 0 = ALUOut, 1 = MDR, 2 = PC+4 from the datapath incrementer.
- `alu_src_a` out 1: ALU operand A select. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU operand B select. 0 = register B, 1 = constant 4, 2 = immediate.
- `alu_op` out 4: operation code sent to the ALU.
- `is_ecall` out 1: pulses for one cycle when an ECALL is decoded.

## Operation
- States are IF, ID, EX, MEM, WB, PC_INC. The state register is the only storage in the block. All outputs are a combinational function of the state and the current `opcode`/`funct3`/`funct7`.
- Any output not listed for a state is 0. A default `alu_op` means ADD.
- **IF:** `mem_read=1`, `iord=0`, `ir_write=1`. Next state is ID.
- **ID:** `alu_src_a=0`, `alu_src_b=2`, ADD. This computes PC+imm into ALUOut.
  - For ECALL (1110011): `is_ecall=1`, next state PC_INC.
  - For an unknown opcode: next state PC_INC, so the instruction executes as a NOP.
  - Otherwise: next state EX.
- **EX, R-type (0110011):** `alu_src_a=1`, `alu_src_b=0`, `alu_op` from the decoder. Next state WB.
- **EX, I-arith (0010011):** `alu_src_a=1`, `alu_src_b=2`, `alu_op` from the decoder. Next state WB.
- **EX, LOAD (0000011) / STORE (0100011):** `alu_src_a=1`, `alu_src_b=2`, ADD. Next state MEM.
- **EX, BRANCH (1100011):**
  - `alu_src_a=1`, `alu_src_b=0`, branch `alu_op` from the decoder.
  - `pc_source=1`, `pc_write_cond=alu_bcond`.
  - Next state is IF if `alu_bcond=1`, otherwise PC_INC.
- **EX, JAL (1101111):** `alu_src_a=0`, `alu_src_b=2`, ADD, `pc_write=1`, `pc_source=0`, `reg_write=1`, `wb_sel=2`. Next state IF.
- **EX, JALR (1100111):** as JAL but with `alu_src_a=1`.
- **MEM:** `iord=1`.
  - Load: `mem_read=1`, next state WB.
  - Store: `mem_write=1`, next state PC_INC.
- **WB:** `reg_write=1`, `wb_sel` = 1 for a load, 0 otherwise. Next state PC_INC.
- **PC_INC:** `alu_src_a=0`, `alu_src_b=1`, ADD, `pc_write=1`, `pc_source=0`. Next state IF.
- **ALU decode for R-type and I-arith, by `funct3`:**
  - 000: SUB only when R-type and `funct7[5]=1`; otherwise ADD.
  - 001: SLL. 100: XOR. 101: SRL. 110: OR. 111: AND.
  - 010 and 011: ADD.
- **ALU decode for branches, by `funct3`:** 000 BEQ, 001 BNE, 100 BLT, 101 BGE. Any other value gives BEQ.
- **`alu_op` encoding:** ADD=0, SUB=1, OR=2, AND=3, SLL=4, SRL=5, XOR=6, BEQ=7, BNE=8, BLT=9, BGE=10.

## Timing
- **Reset:** while `reset=1`, all outputs are forced to 0. The first rising edge with `reset=1` loads IF.
  - A reset asserted mid-instruction aborts the instruction at the next edge.
  - No write enable is asserted in the reset cycle.
- **Cycles per instruction, counted from IF:**
  - R/I-arith: 5.
  - Load: 6.
  - Store: 5.
  - Branch taken: 3. Branch not taken: 4.
  - JAL/JALR: 3.
  - ECALL: 3. Unknown opcode: 3.
- IR changes only on the IF edge. The opcode inputs are therefore stable from ID through PC_INC.
- `alu_bcond` is sampled in EX in the same cycle it is produced, with a purely combinational path to `pc_write_cond` and to the next-state logic.
- In EX for a branch, the PC is updated and the state returns to IF on the same edge.

## Structure
- The state encodings, opcode constants and `alu_op` constants belong in the shared `opcodes.v` header. The ALU also uses that header.
- The funct-to-`alu_op` decoding is a natural sub-module, `alu_control_unit`. It is purely combinational, with inputs `opcode`, `funct3`, `funct7` and a `use_funct` flag from the FSM, and output `alu_op`.

## Test plan
- **Reset:** hold `reset=1` for 2 cycles, then release. All outputs read 0 during reset. The first cycle after release shows IF: `mem_read=1`, `ir_write=1`.
- **R-type SUB:** opcode 0110011, funct3 000, funct7 0100000. `alu_op=1` in EX, `reg_write=1` with `wb_sel=0` in WB, `pc_write=1` in PC_INC. Total 5 cycles.
- **Load:** opcode 0000011. `iord=1` and `mem_read=1` in MEM, then `wb_sel=1` and `reg_write=1` in WB. Total 6 cycles.
- **BNE:** funct3 001.
  - With `alu_bcond=1`: `alu_op=8`, `pc_write_cond=1`, `pc_source=1`, next state IF (3 cycles).
  - With `alu_bcond=0`: `pc_write_cond=0`, then PC_INC (4 cycles).
- **JALR:** opcode 1100111. In EX, `alu_src_a=1`, `alu_src_b=2`, `pc_write=1`, `reg_write=1`, `wb_sel=2`, then IF.
- **ECALL:** opcode 1110011 gives `is_ecall=1` for exactly one cycle in ID.
- **Unknown opcode:** opcode 0000000 takes 3 cycles with no `reg_write` or `mem_write`.
- **Reset mid-instruction:** assert reset during MEM of a store. `mem_write` is 0 in that cycle and the state is IF after release.
